rescale_fetch_ctrl: RTL and testbench
=====================================

RESCALE_FETCH_CTRL -- requirements
Module: rescale_fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, source frame-buffer pixel-address width.
REQ-002 SHALL have parameter DIM_W, default 11, width of every frame dimension input.
REQ-003 Ports (SHALL): clk  input  1  sole clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; latches all configuration inputs and begins a frame.
REQ-006 src_w, src_h, dst_w, dst_h  input  DIM_W each  source/destination dimensions in pixels.
REQ-007 step_r, step_c  input  16 each  source step per destination pixel, unsigned Q11.5.
REQ-008 busy  output  1  high from the cycle after accepted start until done.
REQ-009 done  output  1  one-cycle pulse after the last pixel handshake.
REQ-010 rd_req  output  1  one-cycle read-request pulse; rd_addr  output  ADDR_W  pixel index r*src_w+c.
REQ-011 rd_valid  input  1 and rd_data  input  16 (RGB565): read response, at least 1 cycle after rd_req, one outstanding.
REQ-012 n0, n1, n2, n3  output  16 each  neighbours (r0,c0), (r1,c0), (r0,c1), (r1,c1).
REQ-013 m3, m4, m5, m6  output  16 each  Q11.5 weights (1-dr)(1-dc), dr(1-dc), (1-dr)dc, dr*dc.
REQ-014 out_valid  output  1; out_ready  input  1; out_last  output  1 (high with the final pixel).

Function
REQ-015 FSM states SHALL be IDLE, COORD, RD0, WT0, RD1, WT1, RD2, WT2, RD3, WT3, EMIT, FIN.
REQ-016 IDLE + start: latch config, zero row/column counters and accumulators, go COORD; start is ignored outside IDLE.
REQ-017 start with dst_w==0 or dst_h==0 SHALL go straight to FIN: no reads, no out_valid, done one cycle later.
REQ-018 Accumulators acc_r and acc_c are 16-bit Q11.5; r0=acc_r[15:5], dr=acc_r[4:0], c0=acc_c[15:5], dc=acc_c[4:0].
REQ-019 r0 clamps to src_h-1 and c0 to src_w-1; r1=min(r0+1,src_h-1), c1=min(c0+1,src_w-1); weights keep the unclamped fractions.
REQ-020 COORD computes all four addresses in one cycle; RDk pulses rd_req with address k; WTk waits for rd_valid and captures rd_data into nk.
REQ-021 Weights SHALL be ((32-dr)*(32-dc))>>5, (dr*(32-dc))>>5, ((32-dr)*dc)>>5, (dr*dc)>>5, zero-extended to 16 bits.
REQ-022 EMIT asserts out_valid; n*, m*, out_last stay stable until out_valid&&out_ready, then the counters advance.
REQ-023 Advance: acc_c+=step_c and col+=1; at col==dst_w-1 instead col=0, acc_c=0, acc_r+=step_r, row+=1.
REQ-024 Accumulators SHALL wrap modulo 2^16 with no saturation; configuration is the caller's responsibility.
REQ-025 After the handshake with out_last=1 go FIN; FIN pulses done and returns to IDLE the next cycle.
REQ-026 rd_valid outside a WT state SHALL be ignored.
REQ-027 Per-pixel latency SHALL be 1 + 4*(2+L) + 1 cycles minimum, L = memory wait cycles beyond one.

Reset
REQ-028 reset SHALL force IDLE with busy, done, rd_req, out_valid, out_last=0 and rd_addr, n*, m*, counters, accumulators=0.
REQ-029 Reset mid-frame SHALL abandon the frame; a response arriving after reset deassertion SHALL be ignored.

Structure
REQ-030 Package rescale_pkg SHALL hold FRAC_BITS=5, ONE=16'd32, the FSM state encoding and the default widths.
REQ-031 Weight arithmetic SHALL live in sub-module rescale_weight_gen (dr, dc in; m3..m6 out, combinational).

Verification
REQ-032 src 4x4, dst 8x8, step 16 (0.5): 64 outputs; pixel (0,1) gives m3=16, m5=16, m4=m6=0, addrs 0,4,1,5.
REQ-033 src 4x4, dst 2x2, step 64: pixel (1,1) reads addrs 10,14,11,15 with m3=32; out_last only on the 4th output.
REQ-034 Edge clamp: src 2x2, dst 4x4, step 16: pixel (3,3) gives r0=r1=1, c0=c1=1 (all addrs 3), m6=8.
REQ-035 Hold out_ready low for 10 cycles in EMIT: out_valid, n*, m* unchanged and no new rd_req.
REQ-036 dst_w=0: done exactly 2 cycles after start with no rd_req; a second start while busy is ignored.
REQ-037 Reset asserted in WT2: all outputs reach reset values immediately; a late rd_valid is ignored; next start runs normally.

Source files
------------

// File: rtl/rescale_pkg.sv
// Shared constants and FSM encoding for the bilinear rescale fetch controller.
package rescale_pkg;

    localparam int          FRAC_BITS  = 5;
    localparam logic [15:0] ONE        = 16'd32;
    localparam int          ADDR_W_DEF = 19;
    localparam int          DIM_W_DEF  = 11;

    typedef enum logic [3:0] {
        IDLE, COORD, RD0, WT0, RD1, WT1, RD2, WT2, RD3, WT3, EMIT, FIN
    } state_t;

endpackage

// File: rtl/rescale_weight_gen.sv
// Bilinear weights from the Q11.5 fractional parts of the row/column positions.
module rescale_weight_gen
    import rescale_pkg::*;
(
    input  logic [FRAC_BITS-1:0] dr,
    input  logic [FRAC_BITS-1:0] dc,
    output logic [15:0]          m3,
    output logic [15:0]          m4,
    output logic [15:0]          m5,
    output logic [15:0]          m6
);

    logic [15:0] fr, fc, gr, gc;
    logic [15:0] p3, p4, p5, p6;

    // Products never exceed 32*32, so 16-bit arithmetic cannot overflow.
    always_comb begin
        fr = 16'(dr);
        fc = 16'(dc);
        gr = ONE - fr;
        gc = ONE - fc;
        p3 = gr * gc;
        p4 = fr * gc;
        p5 = gr * fc;
        p6 = fr * fc;
        m3 = p3 >> FRAC_BITS;
        m4 = p4 >> FRAC_BITS;
        m5 = p5 >> FRAC_BITS;
        m6 = p6 >> FRAC_BITS;
    end

endmodule

// File: rtl/rescale_fetch_ctrl.sv
// Walks the destination frame, fetches the four source neighbours of each
// pixel one read at a time and presents them with their bilinear weights.
module rescale_fetch_ctrl
    import rescale_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DIM_W  = DIM_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DIM_W-1:0]  src_w,
    input  logic [DIM_W-1:0]  src_h,
    input  logic [DIM_W-1:0]  dst_w,
    input  logic [DIM_W-1:0]  dst_h,
    input  logic [15:0]       step_r,
    input  logic [15:0]       step_c,
    output logic              busy,
    output logic              done,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_valid,
    input  logic [15:0]       rd_data,
    output logic [15:0]       n0,
    output logic [15:0]       n1,
    output logic [15:0]       n2,
    output logic [15:0]       n3,
    output logic [15:0]       m3,
    output logic [15:0]       m4,
    output logic [15:0]       m5,
    output logic [15:0]       m6,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int CW = (DIM_W > 16 - FRAC_BITS) ? DIM_W : 16 - FRAC_BITS;

    state_t state_q, state_d;

    logic [DIM_W-1:0]  src_w_q, src_h_q, dst_w_q, dst_h_q;
    logic [15:0]       step_r_q, step_c_q, acc_r_q, acc_c_q;
    logic [DIM_W-1:0]  row_q, col_q;
    logic [ADDR_W-1:0] addr_q [4];
    logic [ADDR_W-1:0] addr_d [4];
    logic [15:0]       n_q [4];
    logic [15:0]       m_q [4];
    logic [15:0]       wm [4];
    logic              done_q;

    logic [CW-1:0]     r0_raw, c0_raw, h_max, w_max, r0, c0, r1, c1;
    logic              col_end, last_px;

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [CW-1:0] r,
                                                   input logic [CW-1:0] c,
                                                   input logic [DIM_W-1:0] w);
        return ADDR_W'(r) * ADDR_W'(w) + ADDR_W'(c);
    endfunction

    rescale_weight_gen u_wgen (
        .dr (acc_r_q[FRAC_BITS-1:0]),
        .dc (acc_c_q[FRAC_BITS-1:0]),
        .m3 (wm[0]),
        .m4 (wm[1]),
        .m5 (wm[2]),
        .m6 (wm[3])
    );

    // Integer parts clamp to the frame edge; fractions stay as accumulated.
    always_comb begin
        r0_raw    = CW'(acc_r_q[15:FRAC_BITS]);
        c0_raw    = CW'(acc_c_q[15:FRAC_BITS]);
        h_max     = CW'(src_h_q) - CW'(1);
        w_max     = CW'(src_w_q) - CW'(1);
        r0        = (r0_raw > h_max) ? h_max : r0_raw;
        c0        = (c0_raw > w_max) ? w_max : c0_raw;
        r1        = (r0 < h_max) ? r0 + CW'(1) : h_max;
        c1        = (c0 < w_max) ? c0 + CW'(1) : w_max;
        addr_d[0] = pix_addr(r0, c0, src_w_q);
        addr_d[1] = pix_addr(r1, c0, src_w_q);
        addr_d[2] = pix_addr(r0, c1, src_w_q);
        addr_d[3] = pix_addr(r1, c1, src_w_q);
    end

    assign col_end = (col_q == dst_w_q - DIM_W'(1));
    assign last_px = col_end && (row_q == dst_h_q - DIM_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (dst_w == '0 || dst_h == '0) ? FIN : COORD;
            COORD:   state_d = RD0;
            RD0:     state_d = WT0;
            WT0:     if (rd_valid) state_d = RD1;
            RD1:     state_d = WT1;
            WT1:     if (rd_valid) state_d = RD2;
            RD2:     state_d = WT2;
            WT2:     if (rd_valid) state_d = RD3;
            RD3:     state_d = WT3;
            WT3:     if (rd_valid) state_d = EMIT;
            EMIT:    if (out_ready) state_d = last_px ? FIN : COORD;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_w_q  <= '0;
            src_h_q  <= '0;
            dst_w_q  <= '0;
            dst_h_q  <= '0;
            step_r_q <= '0;
            step_c_q <= '0;
            acc_r_q  <= '0;
            acc_c_q  <= '0;
            row_q    <= '0;
            col_q    <= '0;
            done_q   <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                addr_q[k] <= '0;
                n_q[k]    <= '0;
                m_q[k]    <= '0;
            end
        end else begin
            done_q <= (state_q == FIN);
            case (state_q)
                IDLE: if (start) begin
                    src_w_q  <= src_w;
                    src_h_q  <= src_h;
                    dst_w_q  <= dst_w;
                    dst_h_q  <= dst_h;
                    step_r_q <= step_r;
                    step_c_q <= step_c;
                    acc_r_q  <= '0;
                    acc_c_q  <= '0;
                    row_q    <= '0;
                    col_q    <= '0;
                end
                COORD: begin
                    addr_q <= addr_d;
                    m_q    <= wm;
                end
                WT0: if (rd_valid) n_q[0] <= rd_data;
                WT1: if (rd_valid) n_q[1] <= rd_data;
                WT2: if (rd_valid) n_q[2] <= rd_data;
                WT3: if (rd_valid) n_q[3] <= rd_data;
                EMIT: if (out_ready) begin
                    if (col_end) begin
                        col_q   <= '0;
                        acc_c_q <= '0;
                        row_q   <= row_q + DIM_W'(1);
                        acc_r_q <= acc_r_q + step_r_q;
                    end else begin
                        col_q   <= col_q + DIM_W'(1);
                        acc_c_q <= acc_c_q + step_c_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy      = (state_q != IDLE);
        rd_req    = 1'b0;
        rd_addr   = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state_q)
            RD0:     begin rd_req = 1'b1; rd_addr = addr_q[0]; end
            RD1:     begin rd_req = 1'b1; rd_addr = addr_q[1]; end
            RD2:     begin rd_req = 1'b1; rd_addr = addr_q[2]; end
            RD3:     begin rd_req = 1'b1; rd_addr = addr_q[3]; end
            EMIT:    begin out_valid = 1'b1; out_last = last_px; end
            default: ;
        endcase
    end

    assign done = done_q;
    assign n0 = n_q[0];
    assign n1 = n_q[1];
    assign n2 = n_q[2];
    assign n3 = n_q[3];
    assign m3 = m_q[0];
    assign m4 = m_q[1];
    assign m5 = m_q[2];
    assign m6 = m_q[3];

endmodule

// File: tb/tb_rescale_fetch_ctrl.sv
// Directed bench for rescale_fetch_ctrl: vector table of frames plus stall,
// empty-frame and mid-frame reset sequences against a latency-programmable memory.
module tb_rescale_fetch_ctrl;

    localparam int ADDR_W = 19;
    localparam int DIM_W  = 11;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [DIM_W-1:0]  src_w = '0, src_h = '0, dst_w = '0, dst_h = '0;
    logic [15:0]       step_r = '0, step_c = '0;
    logic              busy, done, rd_req, rd_valid, out_valid, out_ready, out_last;
    logic [ADDR_W-1:0] rd_addr;
    logic [15:0]       rd_data;
    logic [15:0]       n0, n1, n2, n3, m3, m4, m5, m6;

    int n_cmp = 0;
    int n_bad = 0;
    int lat   = 0;

    always #5 clk = ~clk;

    rescale_fetch_ctrl #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .src_w(src_w), .src_h(src_h), .dst_w(dst_w), .dst_h(dst_h),
        .step_r(step_r), .step_c(step_c),
        .busy(busy), .done(done), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .n0(n0), .n1(n1), .n2(n2), .n3(n3),
        .m3(m3), .m4(m4), .m5(m5), .m6(m6),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    function automatic logic [15:0] memf(input int a);
        return 16'(a * 7 + 16'h1234);
    endfunction

    // Memory model: answers 1+lat cycles after each request.
    logic              pend = 1'b0;
    int                cnt = 0;
    logic [ADDR_W-1:0] paddr = '0;
    initial begin
        rd_valid = 1'b0;
        rd_data  = '0;
        forever begin
            @(negedge clk);
            rd_valid = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    rd_valid = 1'b1;
                    rd_data  = memf(int'(paddr));
                    pend     = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (rd_req) begin
                pend  = 1'b1;
                paddr = rd_addr;
                cnt   = lat;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        int sw, sh, dw, dh, sr, sc, lat, pr, pc;
        int a0, a1, a2, a3;
        int w3, w4, w5, w6;
        int first;
    } vec_t;

    vec_t vecs [5];

    task automatic cfg(input vec_t v);
        src_w  = DIM_W'(v.sw);
        src_h  = DIM_W'(v.sh);
        dst_w  = DIM_W'(v.dw);
        dst_h  = DIM_W'(v.dh);
        step_r = 16'(v.sr);
        step_c = 16'(v.sc);
        lat    = v.lat;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int cyc, idx, first, lastbad, got, done_seen, total;
        logic [15:0] cn [4];
        logic [15:0] cm [4];
        cfg(v);
        out_ready = 1'b1;
        total = v.dw * v.dh;
        pulse_start();
        cyc = 1; idx = 0; first = -1; lastbad = 0; got = 0; done_seen = 0;
        for (int k = 0; k < 4; k++) begin cn[k] = '0; cm[k] = '0; end
        while (cyc < 5000 && done_seen == 0) begin
            if (out_valid) begin
                if (first < 0) first = cyc;
                if (out_last != (idx == total - 1)) lastbad++;
                if (idx / v.dw == v.pr && idx % v.dw == v.pc) begin
                    got = 1;
                    cn[0] = n0; cn[1] = n1; cn[2] = n2; cn[3] = n3;
                    cm[0] = m3; cm[1] = m4; cm[2] = m5; cm[3] = m6;
                end
                idx++;
            end
            if (done) done_seen = 1;
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("v%0d_done", id), done_seen, 1);
        chk($sformatf("v%0d_count", id), idx, total);
        chk($sformatf("v%0d_latency", id), first, v.first);
        chk($sformatf("v%0d_last", id), lastbad, 0);
        chk($sformatf("v%0d_pix_found", id), got, 1);
        chk($sformatf("v%0d_n0", id), cn[0], memf(v.a0));
        chk($sformatf("v%0d_n1", id), cn[1], memf(v.a1));
        chk($sformatf("v%0d_n2", id), cn[2], memf(v.a2));
        chk($sformatf("v%0d_n3", id), cn[3], memf(v.a3));
        chk($sformatf("v%0d_m3", id), cm[0], v.w3);
        chk($sformatf("v%0d_m4", id), cm[1], v.w4);
        chk($sformatf("v%0d_m5", id), cm[2], v.w5);
        chk($sformatf("v%0d_m6", id), cm[3], v.w6);
    endtask

    initial begin
        int bad, seen, rq;
        logic [15:0] snap [8];

        //        sw sh dw dh  sr  sc lat pr pc  a0  a1  a2  a3  m3 m4 m5 m6 first
        vecs[0] = '{4, 4, 8, 8, 16, 16, 0, 0, 1,  0,  4,  1,  5, 16, 0, 16, 0, 10};
        vecs[1] = '{4, 4, 2, 2, 64, 64, 1, 1, 1, 10, 14, 11, 15, 32, 0, 0, 0, 14};
        vecs[2] = '{2, 2, 4, 4, 16, 16, 0, 3, 3,  3,  3,  3,  3,  8, 8, 8, 8, 10};
        vecs[3] = '{4, 4, 4, 4, 32, 32, 0, 2, 3, 11, 15, 11, 15, 32, 0, 0, 0, 10};
        vecs[4] = '{8, 4, 3, 2, 24, 40, 2, 1, 2,  2, 10,  3, 11,  4, 12, 4, 12, 18};
        out_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_n0", n0, 0);
        chk("rst_m3", m3, 0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Output stall: everything holds while out_ready is low.
        cfg(vecs[1]);
        lat = 0;
        out_ready = 1'b0;
        pulse_start();
        seen = 0;
        for (int c = 0; c < 100 && seen == 0; c++) begin
            if (out_valid) seen = 1;
            else @(negedge clk);
        end
        chk("stall_reach_emit", seen, 1);
        snap[0] = n0; snap[1] = n1; snap[2] = n2; snap[3] = n3;
        snap[4] = m3; snap[5] = m4; snap[6] = m5; snap[7] = m6;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!out_valid || rd_req) bad++;
            if (n0 != snap[0] || n1 != snap[1] || n2 != snap[2] || n3 != snap[3]) bad++;
            if (m3 != snap[4] || m4 != snap[5] || m5 != snap[6] || m6 != snap[7]) bad++;
        end
        chk("stall_hold", bad, 0);
        chk("stall_m3", snap[4], 32);
        chk("stall_n0", snap[0], memf(0));
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 200 && seen == 0; c++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("stall_done", seen, 1);

        // Empty frame, plus a start while busy that must be ignored.
        src_w = 4; src_h = 4; dst_w = 0; dst_h = 4; step_r = 16; step_c = 16;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        dst_w = 2; dst_h = 2;
        chk("empty_busy_c1", busy, 1);
        chk("empty_done_c1", done, 0);
        @(negedge clk);
        start = 1'b0;
        chk("empty_done_c2", done, 1);
        @(negedge clk);
        chk("empty_done_c3", done, 0);
        chk("empty_busy_c3", busy, 0);
        rq = 0;
        for (int c = 0; c < 20; c++) begin
            if (rd_req) rq++;
            @(negedge clk);
        end
        chk("empty_no_reads", rq, 0);

        // Reset while waiting in WT2 with a slow memory.
        cfg(vecs[1]);
        lat = 6;
        pulse_start();
        rq = 0;
        for (int c = 0; c < 100 && rq < 3; c++) begin
            if (rd_req) rq++;
            @(negedge clk);
        end
        chk("rstmid_reads", rq, 3);
        reset = 1'b1;
        #1;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_rd_req", rd_req, 0);
        chk("rstmid_out_valid", out_valid, 0);
        chk("rstmid_n0", n0, 0);
        chk("rstmid_m3", m3, 0);
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (busy || out_valid || rd_req || n2 != 0 || n0 != 0) bad++;
        end
        chk("rstmid_late_ignored", bad, 0);
        chk("rstmid_resp_drained", pend, 0);
        run_vec(5, vecs[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: actual=1 required=0");
        $fatal(1, "timeout");
    end

endmodule
